// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between fetch (master) and memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_unit_fifo.sv
// Small {pc,inst} buffer between memory responses and the decode-facing output register.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  rd_ptr_r;
  logic [AW-1:0]  wr_ptr_r;
  logic [AW:0]    count_r;
  logic           push_ok_s;
  logic           pop_ok_s;

  assign empty     = (count_r == {(AW + 1){1'b0}});
  assign full      = (count_r == DEPTH_C);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // entry storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
        2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, single-outstanding fetch FSM, epoch-tagged responses and a buffered output register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         id_stall,
  fetch_unit_if.master imem,
  output logic [31:0]  if_inst,
  output logic [31:0]  if_pc,
  output logic         if_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e  state_r, state_next_s;
  logic [31:0]   pc_r;
  logic [31:0]   addr_r;
  logic          epoch_r;
  logic          tag_r;
  logic          drop_r;
  logic          enter_req_s;
  logic          resp_ok_s;
  logic          bypass_s;
  logic          push_s;
  logic          pop_s;
  logic          ack_s;
  logic [CW-1:0] cnt_next_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  fetch_entry_t  fifo_head_s;

  assign imem.imem_req  = (state_r == REQ);
  assign imem.imem_addr = addr_r;
  assign ack_s          = (state_r == REQ) & imem.imem_ack;

  // A response is usable only if no redirect happened since its request was issued
  assign resp_ok_s = (state_r == WAIT) & imem.imem_rvalid & (tag_r == epoch_r) & ~drop_r & ~redirect_valid;
  assign pop_s     = ~redirect_valid & ~id_stall & ~fifo_empty_s;
  assign bypass_s  = ~redirect_valid & ~id_stall & fifo_empty_s & resp_ok_s;
  assign push_s    = resp_ok_s & ~bypass_s;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push_s),
    .pop   (pop_s),
    .din   ('{pc: addr_r, inst: imem.imem_rdata}),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // buffer occupancy after this edge, used to decide back-to-back requests
  always_comb begin
    cnt_next_s = fifo_count_s;
    if (redirect_valid) begin
      cnt_next_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   cnt_next_s = fifo_count_s + CW'(1'b1);
        2'b01:   cnt_next_s = fifo_count_s - CW'(1'b1);
        default: cnt_next_s = fifo_count_s;
      endcase
    end
  end

  // fetch FSM next state
  always_comb begin
    state_next_s = state_r;
    enter_req_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_full_s) begin
          state_next_s = REQ;
          enter_req_s  = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (imem.imem_ack) state_next_s = WAIT;
        else               state_next_s = REQ;
      end
      WAIT: begin
        if (imem.imem_rvalid && (cnt_next_s < DEPTH_C)) begin
          state_next_s = REQ;
          enter_req_s  = 1'b1;
        end else if (imem.imem_rvalid) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // PC, epoch and request bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
      epoch_r <= 1'b0;
      tag_r   <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (redirect_valid) begin
        epoch_r <= ~epoch_r;
        pc_r    <= word_align(redirect_pc);
      end else if (ack_s) begin
        pc_r    <= pc_r + 32'd4;
      end
      if (ack_s) tag_r <= epoch_r;
      // a request launched this edge already targets the redirect address
      if (enter_req_s) begin
        addr_r <= redirect_valid ? word_align(redirect_pc) : pc_r;
        drop_r <= 1'b0;
      end else if (redirect_valid && state_r != IDLE) begin
        drop_r <= 1'b1;
      end
    end
  end

  // decode-facing output register with FIFO-empty bypass
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
      if_pc    <= 32'h0000_0000;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
    end else if (!id_stall) begin
      if (!fifo_empty_s) begin
        if_valid <= 1'b1;
        if_inst  <= fifo_head_s.inst;
        if_pc    <= fifo_head_s.pc;
      end else if (bypass_s) begin
        if_valid <= 1'b1;
        if_inst  <= imem.imem_rdata;
        if_pc    <= addr_r;
      end else begin
        if_valid <= 1'b0;
        if_inst  <= NOP_INST;
      end
    end
  end

endmodule
